// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the switch front end and the counter sequencer.
interface counter_sequencer_if;
  logic       start;
  logic       stop;
  logic       step;
  logic       clr_req;
  logic [1:0] rate_sel;
  logic [7:0] limit;
  logic [7:0] count;
  logic       cnt_enable;
  logic       cnt_clear;
  logic [1:0] state;
  logic       running;
  logic       done;

  modport master (
    output start, stop, step, clr_req,
    output rate_sel, limit, count,
    input  cnt_enable, cnt_clear,
    input  state, running, done
  );

  modport slave (
    input  start, stop, step, clr_req,
    input  rate_sel, limit, count,
    output cnt_enable, cnt_clear,
    output state, running, done
  );
endinterface

// File: rtl/counter_sequencer.sv
// Run/pause/step sequencer driving the count-enable and clear
// of the 8-bit toggle counter, with rate divider and terminal stop.
module counter_sequencer #(
  parameter int DIV1 = 4,
  parameter int DIV2 = 16,
  parameter int DIV3 = 64
) (
  input logic clock,
  input logic reset,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] TOP1 = 8'(DIV1 - 1);
  localparam logic [7:0] TOP2 = 8'(DIV2 - 1);
  localparam logic [7:0] TOP3 = 8'(DIV3 - 1);

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [7:0] top;
  logic       clr;
  logic       at_limit;
  logic       tick;

  always_comb begin
    top = 8'd0;
    unique case (bus.rate_sel)
      2'd1:    top = TOP1;
      2'd2:    top = TOP2;
      2'd3:    top = TOP3;
      default: top = 8'd0;
    endcase
  end

  // >= lets an oversized phase left by a rate change tick at once
  assign clr      = bus.clr_req & ~reset;
  assign at_limit = (bus.count == bus.limit);
  assign tick     = (bus.rate_sel == 2'd0) | (div_q >= top);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    if (clr) begin
      state_d = IDLE;
      div_d   = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            div_d   = 8'd0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (at_limit) begin
            state_d = DONE;
          end else begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
          end
        end
        PAUSE: begin
          if (bus.start & ~bus.stop) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (bus.start & ~bus.stop) begin
            state_d = RUN;
            div_d   = 8'd0;
          end
        end
        default: begin
          state_d = IDLE;
          div_d   = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    logic run_go;
    logic step_go;
    run_go  = (state_q == RUN) & ~bus.stop & tick;
    step_go = ((state_q == IDLE) | (state_q == PAUSE))
            & bus.step & ~bus.start;
    bus.cnt_enable = ~clr & ~at_limit & (run_go | step_go);
    bus.cnt_clear  = clr | ((state_q == DONE) & bus.start);
    bus.state      = state_q;
    bus.running    = (state_q == RUN);
    bus.done       = (state_q == DONE);
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run/pause/step controller for the 8-bit toggle-flip-flop counter datapath. Generates the counter's count-enable (bit-0 T input) at a selectable rate, issues clear pulses, and stops the count at a programmable terminal value. It sits between the board switches/keys (after debouncing) and the counter, which keeps its own flip-flops and hex display path.

## Interface
- DIV1, 4, tick period in cycles for rate_sel=1 (2..256)
- DIV2, 16, tick period for rate_sel=2 (2..256)
- DIV3, 64, tick period for rate_sel=3 (2..256)
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- start  in  1  level, sampled each cycle: begin or resume counting
- stop  in  1  level: pause counting
- step  in  1  level: one count-enable while IDLE or PAUSE
- clr_req  in  1  level: clear counter and return to IDLE
- rate_sel  in  2  0 = every cycle, 1/2/3 = every DIV1/DIV2/DIV3 cycles
- limit  in  8  terminal count value
- count  in  8  current counter value, fed back from the datapath
- cnt_enable  out  1  count-enable to the counter; the counter increments at the edge ending a cycle with cnt_enable=1
- cnt_clear  out  1  synchronous clear request to the counter for the current cycle
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- running  out  1  state==RUN
- done  out  1  state==DONE

## Operation
- Reset: state=IDLE, divider=0. Resulting outputs: cnt_enable=0, cnt_clear=0 (clr_req is forced low during reset), running=0, done=0.
- Divider: 8-bit register, active only in RUN; held in PAUSE.
  - DIV is the period selected by rate_sel.
  - tick = (rate_sel==0) | (divider >= DIV-1).
  - On tick, divider goes to 0; otherwise it increments.
  - The >= compare makes a mid-run rate_sel change safe: an oversized divider value ticks on the next RUN cycle and wraps.
- Combinational outputs:
  - at_limit = (count == limit).
  - cnt_enable = ~clr_req & ~at_limit & ((RUN & ~stop & tick) | ((IDLE|PAUSE) & step & ~start)).
  - cnt_clear = clr_req | (DONE & start).
- Transitions, evaluated in priority order per cycle:
  1. clr_req, any state: go to IDLE, divider=0.
  2. IDLE: start goes to RUN with divider=0. step alone stays in IDLE.
  3. RUN: stop goes to PAUSE. Otherwise at_limit goes to DONE with no enable. Otherwise stay in RUN.
  4. PAUSE: start & ~stop goes to RUN with divider held. step alone stays in PAUSE.
  5. DONE: start & ~stop goes to RUN with divider=0 and cnt_clear=1 this cycle. Otherwise stay in DONE.
- Simultaneous events:
  - stop beats start.
  - start beats step.
  - clr_req beats everything.
- A step while at_limit produces no enable.
- limit=0 with count=0: the first RUN cycle detects the limit and the next state is DONE.
- count=255 with limit<255 and an enable: the counter wraps to 0 and counting continues until count equals limit.
- Inputs are levels: a held step produces one enable per cycle. Edge detection and debouncing are upstream.

## Timing
- All state and the divider are registered on the clock rising edge. reset acts asynchronously.
- cnt_enable and cnt_clear are combinational from registered state plus inputs, with no latency.
- Count update: the counter changes at the edge that ends a cnt_enable=1 cycle. count must reflect the new value in the following cycle, so the datapath has zero-latency feedback.
- RUN with rate_sel=0: enable every cycle. The count reaches limit L from 0 in L cycles. DONE is entered at the edge ending the first cycle with count==L.
- RUN with rate_sel=k: the first enable occurs DIVk cycles after entering RUN (divider 0..DIVk-1), then every DIVk cycles.
- Pause and resume: the enable phase is preserved. The next enable follows after the remaining divider cycles.
- Reset asserted mid-RUN: outputs drop immediately. After release, the block sits in IDLE with divider=0.

## Test plan
- Reset, then start for 1 cycle with rate_sel=0, limit=5, count from a model counter starting at 0 -> 5 consecutive cnt_enable pulses, count=5, state=DONE, done=1, no further enables.
- rate_sel=1 (DIV1=4), limit=3 -> enables on cycles 4, 8, 12 after RUN entry; DONE entered at the edge ending cycle 13.
- Pause/resume: rate_sel=2 (DIV2=16); assert stop at divider=10 for 20 cycles, then start -> state=PAUSE with no enables while stopped; after start, the next enable comes 6 cycles later.
- step held 3 cycles in IDLE with count=0 and limit=2 -> exactly 2 enables, count=2, state stays IDLE.
- start and stop together in PAUSE -> remains PAUSE. clr_req during RUN -> cnt_clear=1 that cycle, state=IDLE next cycle, cnt_enable=0.
- In DONE (count=5), start -> cnt_clear=1 for 1 cycle, then RUN from count=0. Assert reset mid-RUN -> state=0 and all outputs 0 without waiting for a clock edge.
